acog_seq: RTL and testbench
===========================

// Module: acog_seq
// PURPOSE
//  Cog instruction sequencer and fetch stage; sits directly upstream of the decode unit.
//  Owns the PC, reads opcodes from cog RAM and drives the 2-bit pipeline state
//  (FETCH/DECODE/EXECUTE/WBACK, encodings from acog_defs.v) consumed by decode/ALU/wback.
//  Applies the PC-update decisions returned by decode and writeback; stalls in WBACK for hub.
// PARAMETERS
//  PC_W      9    PC / cog RAM address width (512 longs)
//  RESET_PC  0    PC value loaded on reset
// PORTS
//  clk_in                    in   1   clock, all state on rising edge
//  rst_n_in                  in   1   asynchronous active-low reset
//  run_i                     in   1   cog enable; low = stop after current instruction
//  ram_addr_o                out  PC_W cog RAM read address (combinational)
//  ram_rd_o                  out  1   RAM read strobe; data valid on ram_data_i next cycle
//  ram_data_i                in   32  cog RAM read data
//  state_o                   out  2   pipeline state to decode/ALU/wback
//  opcode_o                  out  32  fetched opcode, stable DECODE..WBACK
//  pc_o                      out  PC_W PC of instruction in flight
//  pc_plus_1_o               out  PC_W pc_o+1 mod 2^PC_W (CALL return address)
//  save_pc_from_pc_plus_1_i  in   1   from decode: advance sequentially
//  save_pc_from_s_i          in   1   from decode: jump to s_value_i
//  branch_taken_i            in   1   from wback: DJNZ/TJNZ/TJZ taken
//  s_value_i                 in   PC_W jump target (S operand, low bits)
//  hub_wait_i                in   1   hub access pending; hold WBACK
//  brk_en_i                  in   1   breakpoint enable (ACOG_SEQ_BREAK_EN)
//  brk_addr_i                in   PC_W breakpoint address (ACOG_SEQ_BREAK_EN)
//  halted_o                  out  1   1 while in IDLE
//  brk_hit_o                 out  1   sticky breakpoint-hit flag
// BEHAVIOUR
//  Reset (async, rst_n_in=0): internal state IDLE, pc_o=RESET_PC, opcode_o=0, state_o=FETCH,
//   ram_rd_o=0, halted_o=1, brk_hit_o=0. Reset mid-instruction aborts it; no PC update.
//  Internal states IDLE,FETCH,DECODE,EXEC,WBACK; state_o = FETCH in IDLE and FETCH, DECODE,
//   EXECUTE, WBACK otherwise. opcode_o unchanged in IDLE, so decode re-clearing is harmless.
//  IDLE: ram_addr_o=pc_o. If run_i: ram_rd_o=1, brk_hit_o<=0, ->FETCH. Else stay.
//  FETCH: opcode_o<=ram_data_i, ->DECODE. DECODE ->EXEC. EXEC ->WBACK. One cycle each.
//  WBACK: hub_wait_i=1 -> stay, pc_o/opcode_o held, ram_rd_o=0.
//   hub_wait_i=0: pc_next = (save_pc_from_s_i|branch_taken_i) ? s_value_i : pc_o+1;
//   pc_o<=pc_next; ram_addr_o=pc_next. run_i=1 -> ram_rd_o=1, ->FETCH; run_i=0 -> ->IDLE.
//   Neither save_pc input nor branch_taken_i set still advances (pc_o+1): no lock-up.
//  PC arithmetic mod 2^PC_W: 511+1 -> 0. s_value_i used as-is, no masking beyond PC_W.
//  ram_addr_o combinational; ram_rd_o only asserted on IDLE->FETCH and WBACK->FETCH edges.
//  Latency: 4 cycles/instruction with no hub wait; N extra per hub_wait_i cycle.
//  run_i deassert mid-instruction: instruction completes through WBACK, PC updated, then IDLE.
//  halted_o = (state==IDLE), registered with the state.
// CONFIGURATION
//  ACOG_SEQ_BREAK_EN defined: in WBACK exit (hub_wait_i=0) with brk_en_i=1 and
//   pc_next==brk_addr_i -> pc_o<=pc_next, ->IDLE regardless of run_i, brk_hit_o<=1 (sticky
//   until next IDLE->FETCH). Resume needs run_i low-to-high or held high (re-fetches brk_addr).
//  Not defined: brk_en_i/brk_addr_i ignored, brk_hit_o tied 0; ports stay for one bench.
// TESTING
//  Reset, run_i=1, RAM[0]=0xA0FC_0001, no jumps -> state_o 0,1,2,3 repeating, opcode_o=RAM[0]
//   in DECODE; pc_o 0,1,2 every 4 cycles; ram_addr_o=1 with ram_rd_o=1 in first WBACK.
//  pc_o=0x1FF, sequential advance -> pc_o=0x000 next FETCH; pc_plus_1_o=0x000 while at 0x1FF.
//  save_pc_from_s_i=1, s_value_i=0x040 in WBACK -> pc_o=0x040, ram_addr_o=0x040;
//   branch_taken_i=1 alone, s_value_i=0x010 -> pc_o=0x010.
//  hub_wait_i=1 for 5 cycles in WBACK -> state_o=3 for 6 cycles, pc_o unchanged; then advance.
//  run_i drops in DECODE -> completes WBACK, halted_o=1, pc_o=next; rst_n_in low in EXEC ->
//   same cycle pc_o=RESET_PC, state_o=0, opcode_o=0.
//  ACOG_SEQ_BREAK_EN, brk_en_i=1, brk_addr_i=0x003 -> halt with pc_o=3, brk_hit_o=1;
//   run_i toggle -> fetch from 3, brk_hit_o=0. Without macro -> no halt, brk_hit_o=0.

Source files
------------

// File: rtl/acog_seq.sv
// Cog fetch/sequencer stage: owns the PC and drives the 4-phase pipeline state.
// Optional breakpoint halt is enabled by defining ACOG_SEQ_BREAK_EN.
module acog_seq #(
  parameter int              PC_W     = 9,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk_in,
  input  logic            rst_n_in,
  input  logic            run_i,
  output logic [PC_W-1:0] ram_addr_o,
  output logic            ram_rd_o,
  input  logic [31:0]     ram_data_i,
  output logic [1:0]      state_o,
  output logic [31:0]     opcode_o,
  output logic [PC_W-1:0] pc_o,
  output logic [PC_W-1:0] pc_plus_1_o,
  input  logic            save_pc_from_pc_plus_1_i,
  input  logic            save_pc_from_s_i,
  input  logic            branch_taken_i,
  input  logic [PC_W-1:0] s_value_i,
  input  logic            hub_wait_i,
  input  logic            brk_en_i,
  input  logic [PC_W-1:0] brk_addr_i,
  output logic            halted_o,
  output logic            brk_hit_o
);

  localparam logic [1:0] ST_FETCH   = 2'd0;
  localparam logic [1:0] ST_DECODE  = 2'd1;
  localparam logic [1:0] ST_EXECUTE = 2'd2;
  localparam logic [1:0] ST_WBACK   = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_WBACK
  } st_t;

  st_t             state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [31:0]     opcode_q, opcode_d;
  logic            halted_q;
  logic            brk_hit_q, brk_hit_d;
  logic [PC_W-1:0] pc_inc;
  logic [PC_W-1:0] pc_next;
  logic            brk_match;

  assign pc_inc  = pc_q + PC_W'(1);
  // Any jump source wins; otherwise always advance so nothing can lock up
  assign pc_next = (save_pc_from_s_i | branch_taken_i)
                 ? s_value_i : pc_inc;

`ifdef ACOG_SEQ_BREAK_EN
  assign brk_match = brk_en_i && (pc_next == brk_addr_i);
  logic unused_ok;
  assign unused_ok = save_pc_from_pc_plus_1_i;
`else
  assign brk_match = 1'b0;
  logic unused_ok;
  assign unused_ok = ^{save_pc_from_pc_plus_1_i,
                       brk_en_i, brk_addr_i};
`endif

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q   <= S_IDLE;
      pc_q      <= RESET_PC;
      opcode_q  <= '0;
      halted_q  <= 1'b1;
      brk_hit_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      opcode_q  <= opcode_d;
      halted_q  <= (state_d == S_IDLE);
      brk_hit_q <= brk_hit_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    opcode_d  = opcode_q;
    brk_hit_d = brk_hit_q;
    unique case (state_q)
      S_IDLE: begin
        if (run_i) begin
          state_d   = S_FETCH;
          brk_hit_d = 1'b0;
        end
      end
      S_FETCH: begin
        opcode_d = ram_data_i;
        state_d  = S_DECODE;
      end
      S_DECODE: state_d = S_EXEC;
      S_EXEC:   state_d = S_WBACK;
      S_WBACK: begin
        if (!hub_wait_i) begin
          pc_d = pc_next;
          if (brk_match) begin
            state_d   = S_IDLE;
            brk_hit_d = 1'b1;
          end else if (run_i) begin
            state_d = S_FETCH;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    ram_addr_o = pc_q;
    ram_rd_o   = 1'b0;
    state_o    = ST_FETCH;
    unique case (state_q)
      S_IDLE: ram_rd_o = run_i;
      S_FETCH:  state_o = ST_FETCH;
      S_DECODE: state_o = ST_DECODE;
      S_EXEC:   state_o = ST_EXECUTE;
      S_WBACK: begin
        state_o = ST_WBACK;
        if (!hub_wait_i) begin
          ram_addr_o = pc_next;
          ram_rd_o   = run_i & ~brk_match;
        end
      end
      default: state_o = ST_FETCH;
    endcase
  end

  assign opcode_o    = opcode_q;
  assign pc_o        = pc_q;
  assign pc_plus_1_o = pc_inc;
  assign halted_o    = halted_q;
  assign brk_hit_o   = brk_hit_q;

endmodule

// File: tb/tb_acog_seq.sv
// Directed + randomized bench for acog_seq against an instruction-level model.
// Breakpoint expectations follow ACOG_SEQ_BREAK_EN when defined.
module tb_acog_seq;

  logic        clk_in = 1'b0;
  logic        rst_n_in;
  logic        run_i;
  logic [8:0]  ram_addr_o;
  logic        ram_rd_o;
  logic [31:0] ram_data_i;
  logic [1:0]  state_o;
  logic [31:0] opcode_o;
  logic [8:0]  pc_o;
  logic [8:0]  pc_plus_1_o;
  logic        save_pc_from_pc_plus_1_i;
  logic        save_pc_from_s_i;
  logic        branch_taken_i;
  logic [8:0]  s_value_i;
  logic        hub_wait_i;
  logic        brk_en_i;
  logic [8:0]  brk_addr_i;
  logic        halted_o;
  logic        brk_hit_o;

  logic [31:0] mem [512];
  logic [8:0]  pc_m;
  logic        exp_brk;
  int          total = 0;
  int          bad = 0;

  acog_seq dut (
    .clk_in(clk_in),
    .rst_n_in(rst_n_in),
    .run_i(run_i),
    .ram_addr_o(ram_addr_o),
    .ram_rd_o(ram_rd_o),
    .ram_data_i(ram_data_i),
    .state_o(state_o),
    .opcode_o(opcode_o),
    .pc_o(pc_o),
    .pc_plus_1_o(pc_plus_1_o),
    .save_pc_from_pc_plus_1_i(save_pc_from_pc_plus_1_i),
    .save_pc_from_s_i(save_pc_from_s_i),
    .branch_taken_i(branch_taken_i),
    .s_value_i(s_value_i),
    .hub_wait_i(hub_wait_i),
    .brk_en_i(brk_en_i),
    .brk_addr_i(brk_addr_i),
    .halted_o(halted_o),
    .brk_hit_o(brk_hit_o)
  );

  always #5 clk_in = ~clk_in;

  always @(posedge clk_in)
    if (ram_rd_o) ram_data_i <= mem[ram_addr_o];

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  // Precondition: one step after the edge that entered FETCH at pc_m.
  task automatic do_instr(input int hub, input int kind,
                          input logic [8:0] sv,
                          input bit run_after,
                          output bit halted);
    logic [8:0] nxt;
    bit brk;
    chk("f_state", 32'(state_o), 0);
    chk("f_pc", 32'(pc_o), 32'(pc_m));
    chk("f_pc1", 32'(pc_plus_1_o), 32'((pc_m + 10'd1) % 512));
    chk("f_rd", 32'(ram_rd_o), 0);
    chk("f_brk", 32'(brk_hit_o), 32'(exp_brk));
    chk("f_halt", 32'(halted_o), 0);
    tick();
    chk("d_state", 32'(state_o), 1);
    chk("d_op", opcode_o, mem[pc_m]);
    run_i = run_after;
    tick();
    chk("e_state", 32'(state_o), 2);
    save_pc_from_pc_plus_1_i = (kind == 0);
    save_pc_from_s_i = (kind == 1);
    branch_taken_i = (kind == 2);
    s_value_i = sv;
    hub_wait_i = (hub > 0);
    tick();
    for (int i = 0; i < hub; i++) begin
      chk("h_state", 32'(state_o), 3);
      chk("h_pc", 32'(pc_o), 32'(pc_m));
      chk("h_rd", 32'(ram_rd_o), 0);
      chk("h_op", opcode_o, mem[pc_m]);
      tick();
    end
    hub_wait_i = 1'b0;
    #1;
    nxt = (kind == 1 || kind == 2) ? sv : 9'((pc_m + 10'd1) % 512);
`ifdef ACOG_SEQ_BREAK_EN
    brk = brk_en_i && (nxt == brk_addr_i);
`else
    brk = 1'b0;
`endif
    halted = brk || !run_after;
    chk("w_state", 32'(state_o), 3);
    chk("w_addr", 32'(ram_addr_o), 32'(nxt));
    chk("w_rd", 32'(ram_rd_o), 32'(run_after && !brk));
    chk("w_pc", 32'(pc_o), 32'(pc_m));
    tick();
    save_pc_from_pc_plus_1_i = 1'b0;
    save_pc_from_s_i = 1'b0;
    branch_taken_i = 1'b0;
    pc_m = nxt;
    if (brk) exp_brk = 1'b1;
    chk("x_halt", 32'(halted_o), 32'(halted));
    chk("x_pc", 32'(pc_o), 32'(pc_m));
    chk("x_state", 32'(state_o), 0);
  endtask

  task automatic resume();
    chk("i_halt", 32'(halted_o), 1);
    chk("i_addr", 32'(ram_addr_o), 32'(pc_m));
    chk("i_brk", 32'(brk_hit_o), 32'(exp_brk));
    run_i = 1'b0;
    #1;
    chk("i_rd0", 32'(ram_rd_o), 0);
    tick();
    chk("i_stay", 32'(halted_o), 1);
    run_i = 1'b1;
    #1;
    chk("i_rd1", 32'(ram_rd_o), 1);
    chk("i_addr1", 32'(ram_addr_o), 32'(pc_m));
    tick();
    exp_brk = 1'b0;
  endtask

  initial begin
    bit h;
    for (int i = 0; i < 512; i++) mem[i] = $urandom;
    mem[0] = 32'hA0FC_0001;
    rst_n_in = 1'b0;
    run_i = 1'b0;
    save_pc_from_pc_plus_1_i = 1'b0;
    save_pc_from_s_i = 1'b0;
    branch_taken_i = 1'b0;
    s_value_i = '0;
    hub_wait_i = 1'b0;
    brk_en_i = 1'b0;
    brk_addr_i = 9'h003;
    pc_m = 9'h000;
    exp_brk = 1'b0;
    #12;
    chk("r_state", 32'(state_o), 0);
    chk("r_pc", 32'(pc_o), 0);
    chk("r_op", opcode_o, 0);
    chk("r_rd", 32'(ram_rd_o), 0);
    chk("r_halt", 32'(halted_o), 1);
    chk("r_brk", 32'(brk_hit_o), 0);
    rst_n_in = 1'b1;
    tick();
    chk("r_idle", 32'(halted_o), 1);
    run_i = 1'b1;
    #1;
    chk("s_rd", 32'(ram_rd_o), 1);
    chk("s_addr", 32'(ram_addr_o), 0);
    tick();

    for (int i = 0; i < 3; i++) do_instr(0, 0, 9'h0, 1'b1, h);
    do_instr(0, 1, 9'h1FF, 1'b1, h);
    do_instr(0, 0, 9'h0, 1'b1, h);
    do_instr(0, 1, 9'h040, 1'b1, h);
    do_instr(0, 2, 9'h010, 1'b1, h);
    do_instr(0, 3, 9'h155, 1'b1, h);
    do_instr(5, 0, 9'h0, 1'b1, h);
    for (int i = 0; i < 10; i++)
      do_instr(int'($urandom_range(0, 3)),
               int'($urandom_range(0, 3)),
               9'($urandom), 1'b1, h);

    do_instr(1, 0, 9'h0, 1'b0, h);
    resume();
    do_instr(0, 2, 9'h1FE, 1'b1, h);

    tick();
    tick();
    chk("z_exec", 32'(state_o), 2);
    rst_n_in = 1'b0;
    #1;
    chk("z_pc", 32'(pc_o), 0);
    chk("z_state", 32'(state_o), 0);
    chk("z_op", opcode_o, 0);
    chk("z_halt", 32'(halted_o), 1);
    @(negedge clk_in);
    rst_n_in = 1'b1;
    pc_m = 9'h000;
    exp_brk = 1'b0;
    #1;
    chk("z_rd", 32'(ram_rd_o), 1);
    tick();

    brk_en_i = 1'b1;
    brk_addr_i = 9'h003;
    for (int i = 0; i < 3; i++) do_instr(0, 0, 9'h0, 1'b1, h);
    chk("b_pc", 32'(pc_m), 3);
    if (h) resume();
    brk_en_i = 1'b0;
    do_instr(0, 0, 9'h0, 1'b1, h);
    do_instr(2, 1, 9'h0AA, 1'b1, h);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
